// File: rtl/truncate.sv
// truncate: captures a wide source vector and copies its low MAX_L bits into
// the registered digest Y, one LANE_W-bit lane per clock, flagging completion.
module truncate #(
  parameter int WIDTH_IN = 1088,
  parameter int MAX_L    = 512,
  parameter int LANE_W   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                truncate_start,
  input  logic [WIDTH_IN-1:0] Z,
  output logic [MAX_L-1:0]    Y,
  output logic                truncate_done
);

  localparam int NL    = MAX_L / LANE_W;
  localparam int IDX_W = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NL - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Reject illegal parameter combinations at elaboration time.
  if ((MAX_L > WIDTH_IN) || (LANE_W < 1) || ((MAX_L % LANE_W) != 0)) begin : g_bad_params
    $error("truncate: illegal WIDTH_IN/MAX_L/LANE_W combination");
  end

  logic [1:0]          state_r;
  logic [IDX_W-1:0]    lane_r;
  logic [WIDTH_IN-1:0] buf_r;
  logic [LANE_W-1:0]   lane_data_s;
  logic                last_lane_s;

  // The buffer bits above MAX_L are captured but deliberately never copied.
  if (WIDTH_IN > MAX_L) begin : g_upper
    logic unused_upper_s;
    assign unused_upper_s = ^buf_r[WIDTH_IN-1:MAX_L];
  end

  // Select the captured lane currently being copied and detect the final lane.
  always_comb begin
    lane_data_s = buf_r[lane_r*LANE_W +: LANE_W];
    last_lane_s = (lane_r == LAST_LANE);
  end

  // Control FSM, capture buffer and lane-by-lane copy into the digest register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      lane_r        <= '0;
      buf_r         <= '0;
      Y             <= '0;
      truncate_done <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (truncate_start) begin
            buf_r         <= Z;
            Y             <= '0;
            truncate_done <= 1'b0;
            lane_r        <= '0;
            state_r       <= BUSY;
          end else begin
            state_r <= state_r;
          end
        end
        BUSY: begin
          // A start request here is intentionally ignored.
          Y[lane_r*LANE_W +: LANE_W] <= lane_data_s;
          if (last_lane_s) begin
            lane_r        <= '0;
            truncate_done <= 1'b1;
            state_r       <= DONE;
          end else begin
            lane_r <= lane_r + 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          lane_r        <= '0;
          Y             <= '0;
          truncate_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truncate.sv
// Self-checking bench for truncate at default parameters: directed vector
// table, hand-written corner sequences and random vectors against a model.
module tb_truncate;

  localparam int WIDTH_IN = 1088;
  localparam int MAX_L    = 512;
  localparam int LANE_W   = 64;
  localparam int NL       = MAX_L / LANE_W;

  logic                clk;
  logic                reset;
  logic                truncate_start;
  logic [WIDTH_IN-1:0] Z;
  logic [MAX_L-1:0]    Y;
  logic                truncate_done;

  int checks;
  int errors;

  truncate #(.WIDTH_IN(WIDTH_IN), .MAX_L(MAX_L), .LANE_W(LANE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .truncate_start(truncate_start),
    .Z             (Z),
    .Y             (Y),
    .truncate_done (truncate_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic [WIDTH_IN-1:0] z;
    logic [MAX_L-1:0]    y;
  } vec_t;

  vec_t vecs[4];

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [MAX_L-1:0] act, input logic [MAX_L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_done(input string name, input logic exp);
    checks++;
    if (truncate_done !== exp) begin
      errors++;
      $display("FAIL %s done got %b want %b", name, truncate_done, exp);
    end
  endtask

  // Reference: digest is the low MAX_L bits of the captured vector; after k
  // copy cycles only the lowest k lanes of it are visible, the rest zero.
  function automatic logic [MAX_L-1:0] model_partial(input logic [WIDTH_IN-1:0] zc, input int k);
    logic [MAX_L-1:0] full;
    logic [MAX_L-1:0] mask;
    logic [MAX_L-1:0] one;
    full = zc[MAX_L-1:0];
    one  = {{(MAX_L-1){1'b0}}, 1'b1};
    if (k >= NL) mask = '1;
    else         mask = (one << (k * LANE_W)) - one;
    return full & mask;
  endfunction

  // One operation: start with z, scramble Z after capture, optionally pulse a
  // start with z_alt at copy cycle inj, check every cycle and the hold phase.
  task automatic run_op(input string name, input logic [WIDTH_IN-1:0] z, input int inj,
                        input logic [WIDTH_IN-1:0] z_alt);
    Z = z;
    truncate_start = 1'b1;
    step();
    truncate_start = 1'b0;
    Z = ~z;
    chk({name, "_c0_y"}, Y, model_partial(z, 0));
    chk_done({name, "_c0"}, 1'b0);
    for (int c = 1; c <= NL; c++) begin
      if (c == inj) begin
        truncate_start = 1'b1;
        Z = z_alt;
      end else begin
        truncate_start = 1'b0;
      end
      step();
      chk_done($sformatf("%s_c%0d", name, c), (c == NL));
      if (c == NL) chk({name, "_y"}, Y, model_partial(z, NL));
    end
    truncate_start = 1'b0;
    for (int h = 0; h < 3; h++) begin
      Z = z_alt;
      step();
    end
    chk_done({name, "_hold"}, 1'b1);
    chk({name, "_hold_y"}, Y, model_partial(z, NL));
  endtask

  initial begin
    logic [WIDTH_IN-1:0] zr;
    logic [WIDTH_IN-1:0] za;
    logic [WIDTH_IN-1:0] lanes;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    truncate_start = 1'b1;
    Z = '1;

    lanes = '0;
    for (int i = 0; i < NL; i++) lanes[i*LANE_W +: LANE_W] = 64'(i);
    lanes[WIDTH_IN-1:MAX_L] = '1;

    vecs[0] = '{name: "low_ones",  z: {{(WIDTH_IN-MAX_L){1'b0}}, {MAX_L{1'b1}}}, y: {MAX_L{1'b1}}};
    vecs[1] = '{name: "high_ones", z: {{(WIDTH_IN-MAX_L){1'b1}}, {MAX_L{1'b0}}}, y: {MAX_L{1'b0}}};
    vecs[2] = '{name: "lanes",     z: lanes, y: lanes[MAX_L-1:0]};
    vecs[3] = '{name: "alt_bits",  z: {(WIDTH_IN/2){2'b10}}, y: {(MAX_L/2){2'b10}}};

    // Reset held two cycles with start asserted: must stay cleared.
    step();
    step();
    chk("rst_y", Y, '0);
    chk_done("rst", 1'b0);
    reset = 1'b0;
    truncate_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk_done("rst_idle", 1'b0);
    chk("rst_idle_y", Y, '0);

    // Directed vector table, each checked per cycle.
    for (int v = 0; v < 4; v++) begin
      run_op(vecs[v].name, vecs[v].z, 0, '0);
      chk({vecs[v].name, "_tbl"}, Y, vecs[v].y);
    end

    // Start while busy is ignored, then restart from DONE.
    run_op("busy_start", vecs[2].z, 3, vecs[0].z);
    run_op("restart", vecs[3].z, 0, '0);

    // Reset at busy cycle 4 aborts; block then idles until a new start.
    Z = vecs[0].z;
    truncate_start = 1'b1;
    step();
    truncate_start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_y", Y, '0);
    chk_done("abort", 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("abort_idle_y", Y, '0);
    chk_done("abort_idle", 1'b0);
    run_op("after_abort", vecs[2].z, 0, '0);

    // Random vectors with random ignored starts while busy.
    for (int r = 0; r < 10; r++) begin
      for (int w = 0; w < WIDTH_IN/32; w++) begin
        zr[w*32 +: 32] = $urandom;
        za[w*32 +: 32] = $urandom;
      end
      run_op($sformatf("rand%0d", r), zr, int'($urandom_range(0, NL)), za);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
